led_btn_ctrl: RTL and testbench



---
 rtl/led_btn_ctrl_pkg.sv | 19 +
 rtl/btn_debounce.sv | 62 ++++++
 rtl/led_btn_ctrl.sv | 82 ++++++++
 tb/tb_led_btn_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/led_btn_ctrl_pkg.sv
// rtl/led_btn_ctrl_pkg.sv - shared mode encodings and timing defaults for led_btn_ctrl
package led_btn_ctrl_pkg;

   // LED drive modes, as seen on the 2-bit mode input
   localparam logic [1:0] MODE_FOLLOW = 2'b00;
   localparam logic [1:0] MODE_TOGGLE = 2'b01;
   localparam logic [1:0] MODE_BLINK  = 2'b10;
   localparam logic [1:0] MODE_ALL0   = 2'b11;

   // Defaults for a 12 MHz board clock: 1 ms debounce, 0.5 s blink half-period
   localparam int DEF_DEBOUNCE_CYCLES = 12000;
   localparam int DEF_BLINK_DIV       = 6000000;

   // Counter width able to hold 0..limit-1; never below one bit
   function automatic int cnt_width(input int limit);
      return (limit <= 2) ? 1 : $clog2(limit);
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - one button channel: synchroniser, debounce counter, press strobe
module btn_debounce
   import led_btn_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_n_i,
   output logic db_o,
   output logic press_pulse_o
);

   localparam int             CW      = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   // Synchroniser holds the raw active-low pin level, so 1 means released
   logic          sync1_q, sync2_q;
   logic          pressed;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          db_q, db_d;
   logic          pulse_q, pulse_d;

   assign pressed = ~sync2_q;

   // Debounce: any return to the current debounced level restarts the count
   always_comb begin
      cnt_d   = cnt_q;
      db_d    = db_q;
      pulse_d = 1'b0;
      if (pressed == db_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
         db_d    = ~db_q;
         cnt_d   = '0;
         pulse_d = ~db_q;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // Channel state registers; reset leaves the channel released and idle
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         cnt_q   <= '0;
         db_q    <= 1'b0;
         pulse_q <= 1'b0;
      end else begin
         sync1_q <= btn_n_i;
         sync2_q <= sync1_q;
         cnt_q   <= cnt_d;
         db_q    <= db_d;
         pulse_q <= pulse_d;
      end
   end

   assign db_o          = db_q;
   assign press_pulse_o = pulse_q;

endmodule

// File: rtl/led_btn_ctrl.sv
// rtl/led_btn_ctrl.sv - N-channel button-to-LED controller with four display modes
module led_btn_ctrl
   import led_btn_ctrl_pkg::*;
#(
   parameter int N               = 4,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int BLINK_DIV       = DEF_BLINK_DIV
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] BTN,
   input  logic [1:0]   mode,
   output logic [N-1:0] LED,
   output logic [N-1:0] press_pulse
);

   localparam int             BW        = cnt_width(BLINK_DIV);
   localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);

   logic [N-1:0]  db;
   logic [N-1:0]  toggle_q, toggle_d;
   logic [BW-1:0] blink_cnt_q, blink_cnt_d;
   logic          phase_q, phase_d;
   logic [N-1:0]  led_q, led_d;

   for (genvar i = 0; i < N; i++) begin : g_ch
      btn_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
         .clk           (clk),
         .rst           (rst),
         .btn_n_i       (BTN[i]),
         .db_o          (db[i]),
         .press_pulse_o (press_pulse[i])
      );
   end

   // Toggle latch flips on each press regardless of mode, so it survives mode changes
   always_comb begin
      toggle_d = toggle_q ^ press_pulse;
   end

   // Free-running blink divider; phase flips on every wrap
   always_comb begin
      blink_cnt_d = blink_cnt_q + BW'(1);
      phase_d     = phase_q;
      if (blink_cnt_q == BLINK_MAX) begin
         blink_cnt_d = '0;
         phase_d     = ~phase_q;
      end
   end

   // LED source select; result is registered, so it lags its inputs by one cycle
   always_comb begin
      led_d = '0;
      case (mode)
         MODE_FOLLOW: led_d = db;
         MODE_TOGGLE: led_d = toggle_q;
         MODE_BLINK:  led_d = toggle_q & {N{phase_q}};
         MODE_ALL0:   led_d = {N{db[0]}};
         default:     led_d = '0;
      endcase
   end

   // Top-level state registers
   always_ff @(posedge clk) begin
      if (rst) begin
         toggle_q    <= '0;
         blink_cnt_q <= '0;
         phase_q     <= 1'b0;
         led_q       <= '0;
      end else begin
         toggle_q    <= toggle_d;
         blink_cnt_q <= blink_cnt_d;
         phase_q     <= phase_d;
         led_q       <= led_d;
      end
   end

   assign LED = led_q;

endmodule

// File: tb/tb_led_btn_ctrl.sv
// tb/tb_led_btn_ctrl.sv - table-driven self-checking bench for led_btn_ctrl
module tb_led_btn_ctrl;
   import led_btn_ctrl_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] BTN = 4'b0000;
   logic [1:0] mode = MODE_FOLLOW;
   logic [3:0] LED;
   logic [3:0] press_pulse;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic       r;
      logic [3:0] btn;
      logic [1:0] m;
      logic [3:0] led;
      logic [3:0] pulse;
   } vec_t;

   vec_t vecs[$];

   always #5 clk = ~clk;

   led_btn_ctrl #(
      .N               (4),
      .DEBOUNCE_CYCLES (4),
      .BLINK_DIV       (8)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .BTN         (BTN),
      .mode        (mode),
      .LED         (LED),
      .press_pulse (press_pulse)
   );

   task automatic add(input int n, input logic r, input logic [3:0] b, input logic [1:0] m,
                      input logic [3:0] led, input logic [3:0] p);
      vec_t v;
      v.r = r; v.btn = b; v.m = m; v.led = led; v.pulse = p;
      for (int k = 0; k < n; k++) vecs.push_back(v);
   endtask

   task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b want %b", name, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [3:0] prev;
      logic [3:0] val;
      int         n;
      bit         seen;

      // reset held with all buttons pressed, then the first press after release of rst
      add(3, 1, 4'b0000, MODE_FOLLOW, 4'b0000, 4'b0000);
      add(5, 0, 4'b0000, MODE_FOLLOW, 4'b0000, 4'b0000);
      add(1, 0, 4'b0000, MODE_FOLLOW, 4'b0000, 4'b1111);
      add(1, 0, 4'b0000, MODE_FOLLOW, 4'b1111, 4'b0000);
      add(6, 0, 4'b1111, MODE_FOLLOW, 4'b1111, 4'b0000);
      add(1, 0, 4'b1111, MODE_FOLLOW, 4'b0000, 4'b0000);
      add(2, 1, 4'b1111, MODE_FOLLOW, 4'b0000, 4'b0000);
      // follow latency on channel 1, press then release
      add(2, 0, 4'b1111, MODE_FOLLOW, 4'b0000, 4'b0000);
      add(5, 0, 4'b1101, MODE_FOLLOW, 4'b0000, 4'b0000);
      add(1, 0, 4'b1101, MODE_FOLLOW, 4'b0000, 4'b0010);
      add(2, 0, 4'b1101, MODE_FOLLOW, 4'b0010, 4'b0000);
      add(6, 0, 4'b1111, MODE_FOLLOW, 4'b0010, 4'b0000);
      add(1, 0, 4'b1111, MODE_FOLLOW, 4'b0000, 4'b0000);
      // bounce on channel 2 never qualifies
      add(3, 0, 4'b1011, MODE_FOLLOW, 4'b0000, 4'b0000);
      add(1, 0, 4'b1111, MODE_FOLLOW, 4'b0000, 4'b0000);
      add(3, 0, 4'b1011, MODE_FOLLOW, 4'b0000, 4'b0000);
      add(6, 0, 4'b1111, MODE_FOLLOW, 4'b0000, 4'b0000);
      add(2, 1, 4'b1111, MODE_FOLLOW, 4'b0000, 4'b0000);
      // toggle mode: two presses of channel 0, then channels 3 and 1 together
      add(2, 0, 4'b1111, MODE_TOGGLE, 4'b0000, 4'b0000);
      add(5, 0, 4'b1110, MODE_TOGGLE, 4'b0000, 4'b0000);
      add(1, 0, 4'b1110, MODE_TOGGLE, 4'b0000, 4'b0001);
      add(1, 0, 4'b1110, MODE_TOGGLE, 4'b0000, 4'b0000);
      add(1, 0, 4'b1110, MODE_TOGGLE, 4'b0001, 4'b0000);
      add(7, 0, 4'b1111, MODE_TOGGLE, 4'b0001, 4'b0000);
      add(5, 0, 4'b1110, MODE_TOGGLE, 4'b0001, 4'b0000);
      add(1, 0, 4'b1110, MODE_TOGGLE, 4'b0001, 4'b0001);
      add(1, 0, 4'b1110, MODE_TOGGLE, 4'b0001, 4'b0000);
      add(1, 0, 4'b1110, MODE_TOGGLE, 4'b0000, 4'b0000);
      add(7, 0, 4'b1111, MODE_TOGGLE, 4'b0000, 4'b0000);
      add(5, 0, 4'b0101, MODE_TOGGLE, 4'b0000, 4'b0000);
      add(1, 0, 4'b0101, MODE_TOGGLE, 4'b0000, 4'b1010);
      add(1, 0, 4'b0101, MODE_TOGGLE, 4'b0000, 4'b0000);
      add(1, 0, 4'b0101, MODE_TOGGLE, 4'b1010, 4'b0000);
      add(7, 0, 4'b1111, MODE_TOGGLE, 4'b1010, 4'b0000);
      // legacy all-from-button-0, then button 3 alone
      add(2, 1, 4'b1111, MODE_ALL0, 4'b0000, 4'b0000);
      add(2, 0, 4'b1111, MODE_ALL0, 4'b0000, 4'b0000);
      add(5, 0, 4'b1110, MODE_ALL0, 4'b0000, 4'b0000);
      add(1, 0, 4'b1110, MODE_ALL0, 4'b0000, 4'b0001);
      add(2, 0, 4'b1110, MODE_ALL0, 4'b1111, 4'b0000);
      add(5, 0, 4'b0111, MODE_ALL0, 4'b1111, 4'b0000);
      add(1, 0, 4'b0111, MODE_ALL0, 4'b1111, 4'b1000);
      add(2, 0, 4'b0111, MODE_ALL0, 4'b0000, 4'b0000);
      add(7, 0, 4'b1111, MODE_ALL0, 4'b0000, 4'b0000);
      // reset two counts into a debounce: no pulse, count starts over
      add(4, 0, 4'b1110, MODE_FOLLOW, 4'b0000, 4'b0000);
      add(2, 1, 4'b1110, MODE_FOLLOW, 4'b0000, 4'b0000);
      add(5, 0, 4'b1110, MODE_FOLLOW, 4'b0000, 4'b0000);
      add(1, 0, 4'b1110, MODE_FOLLOW, 4'b0000, 4'b0001);
      add(1, 0, 4'b1110, MODE_FOLLOW, 4'b0001, 4'b0000);
      add(6, 0, 4'b1111, MODE_FOLLOW, 4'b0001, 4'b0000);
      add(1, 0, 4'b1111, MODE_FOLLOW, 4'b0000, 4'b0000);

      foreach (vecs[i]) begin
         rst  = vecs[i].r;
         BTN  = vecs[i].btn;
         mode = vecs[i].m;
         tick();
         check4($sformatf("v%0d led", i), LED, vecs[i].led);
         check4($sformatf("v%0d pulse", i), press_pulse, vecs[i].pulse);
      end

      // blink: latch channels 0 and 2, then watch the blink cadence
      rst = 1'b1; BTN = 4'b1111; mode = MODE_TOGGLE;
      tick(); tick();
      rst = 1'b0;
      tick(); tick();
      BTN = 4'b1010;
      for (int k = 0; k < 8; k++) tick();
      BTN = 4'b1111;
      for (int k = 0; k < 7; k++) tick();
      check4("blink_pre_toggle", LED, 4'b0101);

      mode = MODE_BLINK;
      tick();
      prev = LED;
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         tick();
         if (LED !== prev) seen = 1'b1;
      end
      check_int("blink_first_edge_seen", int'(seen), 1);
      for (int h = 0; h < 3; h++) begin
         check4($sformatf("blink_val%0d", h), LED, prev ^ 4'b0101);
         val = LED;
         n = 1;
         seen = 1'b0;
         while (!seen && n < 20) begin
            tick();
            if (LED === val) n++;
            else seen = 1'b1;
         end
         check_int($sformatf("blink_len%0d", h), n, 8);
         prev = val;
      end

      mode = MODE_TOGGLE;
      tick();
      check4("blink_back_to_toggle", LED, 4'b0101);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
